// File: rtl/mvu_job_sched_if.sv
// Bundle of the job-scheduler signals: host-side job handshake, MVU-array
// start/done, and the status/performance outputs.
// master = host/MVU-array side, slave = the scheduler itself.
interface mvu_job_sched_if #(
  parameter int NMVU    = 8,
  parameter int BMVUA   = $clog2(NMVU),
  parameter int BCNTDWN = 29
);

  logic                job_valid;
  logic                job_ready;
  logic [BMVUA-1:0]    job_mvu;
  logic [BCNTDWN-1:0]  job_cntdwn;
  logic [NMVU-1:0]     mvu_start;
  logic [BCNTDWN-1:0]  mvu_countdown;
  logic [NMVU-1:0]     mvu_done;
  logic [NMVU-1:0]     mvu_busy;
  logic                sched_idle;
  logic                spurious_done;
  logic [31:0]         perf_issued;
  logic [31:0]         perf_stall;

  modport master (
    output job_valid, job_mvu, job_cntdwn, mvu_done,
    input  job_ready, mvu_start, mvu_countdown, mvu_busy,
           sched_idle, spurious_done, perf_issued, perf_stall
  );

  modport slave (
    input  job_valid, job_mvu, job_cntdwn, mvu_done,
    output job_ready, mvu_start, mvu_countdown, mvu_busy,
           sched_idle, spurious_done, perf_issued, perf_stall
  );

endinterface

// File: rtl/mvu_job_sched.sv
// In-order MVU job scheduler. Job descriptors are buffered in a small
// circular FIFO; the head job is launched with a registered one-hot start
// pulse once its target MVU is idle. Zero-countdown jobs are dropped.
// Optional performance counters: define MVU_SCHED_PERFCNT_EN.
module mvu_job_sched #(
  parameter int NMVU    = 8,
  parameter int BMVUA   = $clog2(NMVU),
  parameter int BCNTDWN = 29,
  parameter int DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mvu_job_sched_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [BMVUA-1:0]   memMvu_q [DEPTH];
  logic [BCNTDWN-1:0] memCnt_q [DEPTH];
  logic [PW-1:0]      wrPtr_q, wrPtr_d;
  logic [PW-1:0]      rdPtr_q, rdPtr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [NMVU-1:0]    busy_q, busy_d;
  logic [NMVU-1:0]    start_q, start_d;
  logic [BCNTDWN-1:0] countdown_q, countdown_d;
  logic               spurious_q, spurious_d;

  logic               full, empty, push, pop, issue, discard, headBusy;
  logic [BMVUA-1:0]   headMvu;
  logic [BCNTDWN-1:0] headCnt;
  logic [NMVU-1:0]    issueVec;

  // Head-of-queue decision (discard / issue / stall) and all next-state values
  always_comb begin
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
    headMvu     = memMvu_q[rdPtr_q];
    headCnt     = memCnt_q[rdPtr_q];
    headBusy    = busy_q[headMvu];
    push        = bus.job_valid && !full;
    discard     = !empty && (headCnt == '0);
    issue       = !empty && (headCnt != '0) && !headBusy;
    pop         = discard || issue;
    issueVec    = '0;
    if (issue) begin
      issueVec[headMvu] = 1'b1;
    end
    wrPtr_d     = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d     = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    busy_d      = (busy_q & ~bus.mvu_done) | issueVec;
    spurious_d  = spurious_q | (|(bus.mvu_done & ~busy_q));
    start_d     = issueVec;
    countdown_d = issue ? headCnt : countdown_q;
  end

  // FIFO storage: write the incoming descriptor at the write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        memMvu_q[i] <= '0;
        memCnt_q[i] <= '0;
      end
    end else if (push) begin
      memMvu_q[wrPtr_q] <= bus.job_mvu;
      memCnt_q[wrPtr_q] <= bus.job_cntdwn;
    end
  end

  // Pointers, occupancy, busy flags and registered start outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      start_q     <= '0;
      countdown_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      countdown_q <= countdown_d;
      spurious_q  <= spurious_d;
    end
  end

`ifdef MVU_SCHED_PERFCNT_EN
  logic        stall;
  logic [31:0] perfIssued_q, perfStall_q;

  assign stall = !empty && (headCnt != '0) && headBusy;

  // Free-running wrap-around counters of issues and head-of-line stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfIssued_q <= '0;
      perfStall_q  <= '0;
    end else begin
      perfIssued_q <= perfIssued_q + 32'(issue);
      perfStall_q  <= perfStall_q + 32'(stall);
    end
  end

  assign bus.perf_issued = perfIssued_q;
  assign bus.perf_stall  = perfStall_q;
`else
  assign bus.perf_issued = '0;
  assign bus.perf_stall  = '0;
`endif

  assign bus.job_ready     = !full;
  assign bus.mvu_start     = start_q;
  assign bus.mvu_countdown = countdown_q;
  assign bus.mvu_busy      = busy_q;
  assign bus.sched_idle    = empty && (busy_q == '0);
  assign bus.spurious_done = spurious_q;

endmodule

// File: tb/tb_mvu_job_sched.sv
// Scoreboard bench for mvu_job_sched: directed stimulus pushes expected
// start pulses (vector, countdown, cycle) into a queue; an independent
// monitor pops and compares whenever the DUT raises any mvu_start bit.
module tb_mvu_job_sched;

  localparam int NMVU    = 8;
  localparam int BCNTDWN = 29;

`ifdef MVU_SCHED_PERFCNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [NMVU-1:0]    start;
    logic [BCNTDWN-1:0] cnt;
    int                 cyc;
  } expStart_t;

  logic      clk;
  logic      rst_n;
  int        cyc;
  int        checks;
  int        errors;
  logic      acc;
  expStart_t sbQ[$];
  expStart_t monItem;

  mvu_job_sched_if #(.NMVU(NMVU), .BCNTDWN(BCNTDWN)) bus ();

  mvu_job_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to timestamp start pulses
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and report a mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs from a negedge; returns whether a job was taken
  task automatic applyStimulus(input logic valid, input int mvu, input int cnt,
                               input logic [NMVU-1:0] done, output logic accepted);
    accepted       = valid && bus.job_ready;
    bus.job_valid  = valid;
    bus.job_mvu    = 3'(mvu);
    bus.job_cntdwn = 29'(cnt);
    bus.mvu_done   = done;
    @(negedge clk);
    bus.job_valid  = 1'b0;
    bus.job_mvu    = '0;
    bus.job_cntdwn = '0;
    bus.mvu_done   = '0;
  endtask

  // Record an expected start pulse for the monitor
  task automatic expectStart(input int mvu, input int cnt, input int atCycle);
    expStart_t e;
    e.start = 8'(1 << mvu);
    e.cnt   = 29'(cnt);
    e.cyc   = atCycle;
    sbQ.push_back(e);
  endtask

  // All outputs at their reset values
  task automatic checkReset(input string tag);
    checkOutput({tag, "_ready"},     32'(bus.job_ready), 32'd1);
    checkOutput({tag, "_start"},     32'(bus.mvu_start), 32'd0);
    checkOutput({tag, "_countdown"}, 32'(bus.mvu_countdown), 32'd0);
    checkOutput({tag, "_busy"},      32'(bus.mvu_busy), 32'd0);
    checkOutput({tag, "_idle"},      32'(bus.sched_idle), 32'd1);
    checkOutput({tag, "_spurious"},  32'(bus.spurious_done), 32'd0);
    checkOutput({tag, "_perf_iss"},  bus.perf_issued, 32'd0);
    checkOutput({tag, "_perf_stl"},  bus.perf_stall, 32'd0);
  endtask

  // Monitor: every start pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.mvu_start != '0) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_start: got start=0x%0h cnt=%0d at cycle %0d, required no start",
                 bus.mvu_start, bus.mvu_countdown, cyc);
      end else begin
        monItem = sbQ.pop_front();
        checkOutput("start_vector",    32'(bus.mvu_start), 32'(monItem.start));
        checkOutput("start_countdown", 32'(bus.mvu_countdown), 32'(monItem.cnt));
        checkOutput("start_cycle",     32'(cyc), 32'(monItem.cyc));
      end
    end
  end

  // Directed scenarios
  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.job_valid  = 1'b0;
    bus.job_mvu    = '0;
    bus.job_cntdwn = '0;
    bus.mvu_done   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkReset("reset");

    // Single job into an idle scheduler: start two edges after the push edge
    expectStart(2, 100, cyc + 2);
    applyStimulus(1'b1, 2, 100, 8'h00, acc);
    @(negedge clk);
    checkOutput("t1_busy", 32'(bus.mvu_busy), 32'h04);
    checkOutput("t1_idle", 32'(bus.sched_idle), 32'd0);
    applyStimulus(1'b0, 0, 0, 8'h04, acc);
    checkOutput("t1_busy_clr", 32'(bus.mvu_busy), 32'h00);
    checkOutput("t1_idle_back", 32'(bus.sched_idle), 32'd1);

    // Two jobs on MVU 2: second stalls five cycles, issues after the done
    expectStart(2, 10, cyc + 2);
    applyStimulus(1'b1, 2, 10, 8'h00, acc);
    applyStimulus(1'b1, 2, 20, 8'h00, acc);
    repeat (4) @(negedge clk);
    expectStart(2, 20, cyc + 2);
    applyStimulus(1'b0, 0, 0, 8'h04, acc);
    checkOutput("t2_busy_clr", 32'(bus.mvu_busy), 32'h00);
    @(negedge clk);
    checkOutput("t2_busy_again", 32'(bus.mvu_busy), 32'h04);
    checkOutput("t2_perf_stall", bus.perf_stall, PERF ? 32'd5 : 32'd0);
    checkOutput("t2_perf_issued", bus.perf_issued, PERF ? 32'd3 : 32'd0);
    applyStimulus(1'b0, 0, 0, 8'h04, acc);

    // Back-to-back jobs to distinct idle MVUs: one start per cycle
    expectStart(1, 5, cyc + 2);
    applyStimulus(1'b1, 1, 5, 8'h00, acc);
    expectStart(3, 6, cyc + 2);
    applyStimulus(1'b1, 3, 6, 8'h00, acc);
    expectStart(5, 7, cyc + 2);
    applyStimulus(1'b1, 5, 7, 8'h00, acc);
    @(negedge clk);
    checkOutput("t3_busy", 32'(bus.mvu_busy), 32'h2A);
    checkOutput("t3_perf_issued", bus.perf_issued, PERF ? 32'd6 : 32'd0);
    checkOutput("t3_perf_stall", bus.perf_stall, PERF ? 32'd5 : 32'd0);
    applyStimulus(1'b0, 0, 0, 8'h2A, acc);
    checkOutput("t3_idle", 32'(bus.sched_idle), 32'd1);

    // Fill the FIFO behind a busy MVU 0; fifth push refused
    expectStart(0, 1, cyc + 2);
    applyStimulus(1'b1, 0, 1, 8'h00, acc);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 0, 11 + k, 8'h00, acc);
      checkOutput($sformatf("t4_accept%0d", k), 32'(acc), 32'(k < 4));
    end
    checkOutput("t4_ready_full", 32'(bus.job_ready), 32'd0);
    expectStart(0, 11, cyc + 2);
    applyStimulus(1'b0, 0, 0, 8'h01, acc);
    checkOutput("t4_ready_still_full", 32'(bus.job_ready), 32'd0);
    @(negedge clk);
    checkOutput("t4_ready_freed", 32'(bus.job_ready), 32'd1);
    applyStimulus(1'b1, 0, 16, 8'h00, acc);
    checkOutput("t4_accept_after_free", 32'(acc), 32'd1);
    for (int k = 0; k < 4; k++) begin
      expectStart(0, (k == 3) ? 16 : 12 + k, cyc + 2);
      applyStimulus(1'b0, 0, 0, 8'h01, acc);
      @(negedge clk);
    end
    applyStimulus(1'b0, 0, 0, 8'h01, acc);
    checkOutput("t4_idle", 32'(bus.sched_idle), 32'd1);

    // Zero-countdown job is dropped; the next one issues; spurious done
    applyStimulus(1'b1, 4, 0, 8'h00, acc);
    @(negedge clk);
    checkOutput("t5_busy_zero", 32'(bus.mvu_busy), 32'h00);
    checkOutput("t5_idle_zero", 32'(bus.sched_idle), 32'd1);
    expectStart(4, 9, cyc + 2);
    applyStimulus(1'b1, 4, 9, 8'h00, acc);
    @(negedge clk);
    checkOutput("t5_busy", 32'(bus.mvu_busy), 32'h10);
    applyStimulus(1'b0, 0, 0, 8'h10, acc);
    checkOutput("t5_no_spurious", 32'(bus.spurious_done), 32'd0);
    applyStimulus(1'b0, 0, 0, 8'h40, acc);
    checkOutput("t5_spurious", 32'(bus.spurious_done), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t5_spurious_sticky", 32'(bus.spurious_done), 32'd1);
    checkOutput("t5_busy_after", 32'(bus.mvu_busy), 32'h00);

    // Reset with jobs queued behind a busy MVU 1: everything discarded
    expectStart(1, 3, cyc + 2);
    applyStimulus(1'b1, 1, 3, 8'h00, acc);
    @(negedge clk);
    applyStimulus(1'b1, 1, 4, 8'h00, acc);
    applyStimulus(1'b1, 1, 5, 8'h00, acc);
    applyStimulus(1'b1, 1, 6, 8'h00, acc);
    checkOutput("t6_busy", 32'(bus.mvu_busy), 32'h02);
    checkOutput("t6_not_idle", 32'(bus.sched_idle), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_busy", 32'(bus.mvu_busy), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkReset("t6_reset");
    repeat (6) @(negedge clk);
    checkOutput("t6_idle_after", 32'(bus.sched_idle), 32'd1);
    checkOutput("t6_busy_after", 32'(bus.mvu_busy), 32'h00);

    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
